exu_div_unit: RTL and testbench
===============================

Name: exu_div_unit

Overview:
- Iterative radix-2 restoring divider. It is the execution-side responder for the DIV request group that dispatch produces: `req_div`, `op1`/`op2`, one-hot `div`/`divu`/`rem`/`remu`.
- Accepts one request when idle, computes for 32 iterations, then presents a tagged result to the writeback arbiter with a valid/ready handshake.
- Its busy output stalls dispatch.

Parameters:
- XLEN, 32, operand and result width; only 32 is supported.
- RD_W, 5, width of the destination register tag.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- req_div_i  in  1  divide request from dispatch.
- div_op1_i  in  32  dividend (rs1).
- div_op2_i  in  32  divisor (rs2).
- div_op_div_i  in  1  DIV (signed quotient).
- div_op_divu_i  in  1  DIVU (unsigned quotient).
- div_op_rem_i  in  1  REM (signed remainder).
- div_op_remu_i  in  1  REMU (unsigned remainder).
- div_rd_i  in  RD_W  destination register tag.
- flush_i  in  1  pipeline flush; kills any in-flight operation.
- div_busy_o  out  1  unit not idle; dispatch must hold `req`.
- div_wb_valid_o  out  1  result valid.
- div_wb_ready_i  in  1  writeback accepts the result.
- div_wb_data_o  out  32  quotient or remainder.
- div_wb_rd_o  out  RD_W  tag of the result.

Behaviour:
- Reset (async, `rst_n` low):
  - State goes to IDLE.
  - All outputs are 0.
  - Internal dividend, divisor, remainder, counter and opcode registers are cleared.
  - Reset mid-operation discards the operation with no valid pulse.
- States:
  - IDLE, CALC, DONE.
  - `div_busy_o` = (state != IDLE), registered from state.
- Accept condition:
  - Accept = `req_div_i` & IDLE & !`flush_i`.
  - On accept, latch:
    - op bits and `rd`;
    - signed = div|rem;
    - result selection: rem_sel = rem|remu;
    - neg_q = signed & (op1[31] ^ op2[31]) & (op2 != 0);
    - neg_r = signed & op1[31];
    - absolute values |op1| and |op2| (identity when unsigned).
  - Requests outside IDLE are ignored and are not queued.
  - Exactly one op bit is expected with `req`; if none is set, the request is treated as DIVU.
- Special cases on accept (state goes IDLE -> DONE, `div_wb_valid_o` high the cycle after the accepting edge):
  - op2 == 0: quotient = 0xFFFFFFFF; remainder = op1 (raw, unsigned view).
  - Signed and op1 == 0x80000000 and op2 == 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- Normal path (IDLE -> CALC, counter = 0):
  - Each cycle: shift {rem, dvd} left 1; trial = rem_hi - divisor (33-bit).
  - If trial is non-negative: rem_hi = trial and the quotient bit is 1; else the quotient bit is 0.
  - After the iteration with counter == 31, go to DONE.
  - Sign correction is applied on the DONE entry edge: q = neg_q ? -q : q; r = neg_r ? -r : r.
  - Output data = rem_sel ? r : q.
  - Latency: `div_wb_valid_o` is high 33 clocks after the accepting edge.
- DONE:
  - `div_wb_valid_o` = 1.
  - data and `rd` are held stable until `div_wb_ready_i` = 1.
  - On the ready edge go to IDLE; valid drops on that edge.
  - A new request is accepted on the cycle after the return to IDLE.
- Flush:
  - `flush_i` in CALC or DONE sends the state to IDLE on the next edge; valid is cleared and the result is discarded.
  - `flush_i` with valid & ready in the same cycle: flush wins; no writeback credit is implied.
  - `flush_i` in IDLE with `req` present: the request is not accepted.
- Arithmetic:
  - All negation is two's complement mod 2^32.
  - Remainder magnitude < |divisor|.
  - The sign of a nonzero remainder equals the sign of the dividend (RISC-V M semantics).

Test Plan:
- DIV op1=20, op2=0xFFFFFFFD (-3), rd=5 -> valid 33 clocks after accept, data=0xFFFFFFFA, rd=5. Repeat as REM -> data=0x00000002.
- DIVU op1=0xFFFFFFFF, op2=2 -> data=0x7FFFFFFF; REMU -> 0x00000001; `busy` high from the edge after accept until the ready edge.
- DIV 7/0 -> data=0xFFFFFFFF one clock after accept; REM 7/0 -> 0x00000007; REMU 0x80000000/0 -> 0x80000000.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in 1 clock; REM -> 0. Repeat as DIVU -> 33-clock path, data=0.
- Backpressure: `div_wb_ready_i` low for 5 clocks after valid -> valid, data and `rd` constant; a second `req` during CALC/DONE is ignored; a `req` one clock after the ready edge is accepted.
- `flush_i` at iteration 10 -> IDLE next edge, no valid ever. A new DIVU 100/7 is then accepted -> 14. Async `rst_n` pulse mid-CALC -> all outputs 0 immediately, `busy`=0.

Source files
------------

// File: rtl/exu_div_unit.sv
// Iterative radix-2 restoring divider serving the DIV/DIVU/REM/REMU request group.
// Latency: 1 cycle for divide-by-zero / signed overflow, otherwise 33 cycles from accept to valid.
// Backpressure: one op in flight; busy stalls dispatch, the result is held until wb ready, flush kills.
module exu_div_unit #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_div_i,
  input  logic [XLEN-1:0] div_op1_i,
  input  logic [XLEN-1:0] div_op2_i,
  input  logic            div_op_div_i,
  input  logic            div_op_divu_i,
  input  logic            div_op_rem_i,
  input  logic            div_op_remu_i,
  input  logic [RD_W-1:0] div_rd_i,
  input  logic            flush_i,
  output logic            div_busy_o,
  output logic            div_wb_valid_o,
  input  logic            div_wb_ready_i,
  output logic [XLEN-1:0] div_wb_data_o,
  output logic [RD_W-1:0] div_wb_rd_o
);

  localparam int CNT_W = $clog2(XLEN);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN-1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Architectural state
  logic [1:0]      state_q,   state_d;
  logic [XLEN-1:0] dvd_q,     dvd_d;      // dividend shifting out, quotient shifting in
  logic [XLEN-1:0] dvs_q,     dvs_d;      // divisor magnitude
  logic [XLEN-1:0] rem_q,     rem_d;      // partial remainder
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic            neg_q_q,   neg_q_d;
  logic            neg_r_q,   neg_r_d;
  logic            rem_sel_q, rem_sel_d;
  logic [RD_W-1:0] rd_q,      rd_d;
  logic [XLEN-1:0] result_q,  result_d;
  logic            valid_q,   valid_d;
  logic            busy_q,    busy_d;

  // Request decode (only meaningful in IDLE)
  logic            acc_signed;
  logic            acc_rem_sel;
  logic            acc_op2_zero;
  logic            acc_ovf;
  logic            acc_neg_q;
  logic            acc_neg_r;
  logic [XLEN-1:0] acc_abs1;
  logic [XLEN-1:0] acc_abs2;

  // One restoring iteration and the final sign fix-up
  logic [XLEN:0]   rem_shift;
  logic            trial_ge;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  // Decode the incoming op group; an asserted DIVU bit (or no bit at all) means unsigned quotient
  always_comb begin
    acc_signed   = (div_op_div_i | div_op_rem_i) & ~div_op_divu_i;
    acc_rem_sel  = (div_op_rem_i | div_op_remu_i) & ~div_op_divu_i;
    acc_op2_zero = (div_op2_i == '0);
    acc_ovf      = acc_signed & (div_op1_i == MIN_NEG) & (div_op2_i == '1);
    acc_neg_q    = acc_signed & (div_op1_i[XLEN-1] ^ div_op2_i[XLEN-1]) & ~acc_op2_zero;
    acc_neg_r    = acc_signed & div_op1_i[XLEN-1];
    acc_abs1     = (acc_signed & div_op1_i[XLEN-1]) ? (-div_op1_i) : div_op1_i;
    acc_abs2     = (acc_signed & div_op2_i[XLEN-1]) ? (-div_op2_i) : div_op2_i;
  end

  // Shift {rem, dvd} left one place and subtract the divisor when it fits
  always_comb begin
    rem_shift = {rem_q, dvd_q[XLEN-1]};
    trial_ge  = (rem_shift >= {1'b0, dvs_q});
    // When the trial fits, the true difference is below the divisor, so the low XLEN bits are exact.
    rem_next  = trial_ge ? (rem_shift[XLEN-1:0] - dvs_q) : rem_shift[XLEN-1:0];
    quo_next  = {dvd_q[XLEN-2:0], trial_ge};
    quo_fix   = neg_q_q ? (-quo_next) : quo_next;
    rem_fix   = neg_r_q ? (-rem_next) : rem_next;
  end

  // Next-state, operand capture and result formation
  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    rem_sel_d = rem_sel_q;
    rd_d      = rd_q;
    result_d  = result_q;

    case (state_q)
      ST_IDLE: begin
        if (req_div_i && !flush_i) begin
          rd_d      = div_rd_i;
          rem_sel_d = acc_rem_sel;
          neg_q_d   = acc_neg_q;
          neg_r_d   = acc_neg_r;
          dvd_d     = acc_abs1;
          dvs_d     = acc_abs2;
          rem_d     = '0;
          cnt_d     = '0;
          if (acc_op2_zero) begin
            // Divide by zero: all-ones quotient, remainder is the raw dividend
            result_d = acc_rem_sel ? div_op1_i : '1;
            state_d  = ST_DONE;
          end else if (acc_ovf) begin
            // Most-negative / -1 overflows: quotient wraps to itself, remainder 0
            result_d = acc_rem_sel ? '0 : MIN_NEG;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          dvd_d = quo_next;
          rem_d = rem_next;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            result_d = rem_sel_q ? rem_fix : quo_fix;
            state_d  = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // Flush and ready both retire the result; a flush means it was never written back
        if (flush_i || div_wb_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    valid_d = (state_d == ST_DONE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      rem_sel_q <= 1'b0;
      rd_q      <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      rem_sel_q <= rem_sel_d;
      rd_q      <= rd_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign div_busy_o     = busy_q;
  assign div_wb_valid_o = valid_q;
  assign div_wb_data_o  = result_q;
  assign div_wb_rd_o    = rd_q;

endmodule

// File: tb/tb_exu_div_unit.sv
// Bench for exu_div_unit: directed cases with literal results plus randomized traffic.
// Latency: a transaction-level model predicts busy/valid/data/rd every cycle.
// Backpressure: ready is held low or randomized; flush and async reset are exercised.
module tb_exu_div_unit;

  logic        clk;
  logic        rst_n;
  logic        req_div_i;
  logic [31:0] div_op1_i;
  logic [31:0] div_op2_i;
  logic        div_op_div_i;
  logic        div_op_divu_i;
  logic        div_op_rem_i;
  logic        div_op_remu_i;
  logic [4:0]  div_rd_i;
  logic        flush_i;
  logic        div_busy_o;
  logic        div_wb_valid_o;
  logic        div_wb_ready_i;
  logic [31:0] div_wb_data_o;
  logic [4:0]  div_wb_rd_o;

  int errors = 0;
  int checks = 0;
  int cur_op = 1;  // 0=DIV 1=DIVU 2=REM 3=REMU 4=no op bit

  exu_div_unit #(.XLEN(32), .RD_W(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_div_i      (req_div_i),
    .div_op1_i      (div_op1_i),
    .div_op2_i      (div_op2_i),
    .div_op_div_i   (div_op_div_i),
    .div_op_divu_i  (div_op_divu_i),
    .div_op_rem_i   (div_op_rem_i),
    .div_op_remu_i  (div_op_remu_i),
    .div_rd_i       (div_rd_i),
    .flush_i        (flush_i),
    .div_busy_o     (div_busy_o),
    .div_wb_valid_o (div_wb_valid_o),
    .div_wb_ready_i (div_wb_ready_i),
    .div_wb_data_o  (div_wb_data_o),
    .div_wb_rd_o    (div_wb_rd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: RISC-V M semantics computed with plain integer arithmetic
  function automatic logic [31:0] ref_res(input int op, input logic [31:0] a, input logic [31:0] b,
                                          output int lat);
    bit sgn;
    bit want_rem;
    logic [31:0] q;
    logic [31:0] r;
    int sa;
    int sb;
    sgn      = (op == 0) || (op == 2);
    want_rem = (op == 2) || (op == 3);
    lat      = 33;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; lat = 1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; lat = 1;
    end else if (sgn) begin
      sa = $signed(a); sb = $signed(b);
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
    return want_rem ? r : q;
  endfunction

  // Transaction-level model: idle, counting down to the result, or holding a result
  bit          m_busy;
  bit          m_valid;
  int          m_wait;
  logic [31:0] m_data;
  logic [4:0]  m_rd;

  always @(posedge clk or negedge rst_n) begin
    int lat;
    if (!rst_n) begin
      m_busy = 0; m_valid = 0; m_wait = 0;
    end else if (!m_busy) begin
      if (req_div_i && !flush_i) begin
        m_data  = ref_res((cur_op == 4) ? 1 : cur_op, div_op1_i, div_op2_i, lat);
        m_rd    = div_rd_i;
        m_busy  = 1;
        m_wait  = lat - 1;
        m_valid = (m_wait == 0);
      end
    end else if (flush_i) begin
      m_busy = 0; m_valid = 0;
    end else if (m_valid) begin
      if (div_wb_ready_i) begin
        m_busy = 0; m_valid = 0;
      end
    end else begin
      m_wait--;
      if (m_wait == 0) m_valid = 1;
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", {31'd0, div_busy_o}, 32'd0);
      chk("rst_valid", {31'd0, div_wb_valid_o}, 32'd0);
      chk("rst_data", div_wb_data_o, 32'd0);
    end else begin
      chk("busy", {31'd0, div_busy_o}, {31'd0, m_busy});
      chk("valid", {31'd0, div_wb_valid_o}, {31'd0, m_valid});
      if (m_valid) begin
        chk("data", div_wb_data_o, m_data);
        chk("rd", {27'd0, div_wb_rd_o}, {27'd0, m_rd});
      end
    end
  end

  task automatic set_req(input int op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    cur_op        = op;
    div_op_div_i  = (op == 0);
    div_op_divu_i = (op == 1);
    div_op_rem_i  = (op == 2);
    div_op_remu_i = (op == 3);
    div_op1_i     = a;
    div_op2_i     = b;
    div_rd_i      = rd;
  endtask

  // Issue one op (called just after a posedge with the unit idle), check latency, result and hold
  task automatic do_op(input string nm, input int op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int exp_lat,
                       input int hold, input bit spam);
    int cyc;
    bit got;
    set_req(op, a, b, rd);
    req_div_i = 1'b1;
    @(posedge clk); #1;
    req_div_i = 1'b0;
    cyc = 1;
    got = 0;
    while (cyc <= 40) begin
      if (spam && cyc == 3) begin
        req_div_i = 1'b1;
        div_op1_i = 32'd999;
        div_op2_i = 32'd1;
      end
      @(negedge clk);
      if (div_wb_valid_o) begin
        got = 1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL %s_timeout: no valid within 40 cycles", nm);
    end else begin
      chk({nm, "_lat"}, cyc, exp_lat);
      chk({nm, "_data"}, div_wb_data_o, exp);
      chk({nm, "_rd"}, {27'd0, div_wb_rd_o}, {27'd0, rd});
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk({nm, "_hold_valid"}, {31'd0, div_wb_valid_o}, 32'd1);
      chk({nm, "_hold_data"}, div_wb_data_o, exp);
      chk({nm, "_hold_rd"}, {27'd0, div_wb_rd_o}, {27'd0, rd});
    end
    div_wb_ready_i = 1'b1;
    @(posedge clk); #1;
    div_wb_ready_i = 1'b0;
    req_div_i      = 1'b0;
    chk({nm, "_post_busy"}, {31'd0, div_busy_o}, 32'd0);
    chk({nm, "_post_valid"}, {31'd0, div_wb_valid_o}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'd1;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = 32'($urandom_range(0, 20));
      default: v = $urandom();
    endcase
    return v;
  endfunction

  initial begin
    bit seen;
    rst_n = 1'b0;
    req_div_i = 1'b0;
    flush_i = 1'b0;
    div_wb_ready_i = 1'b0;
    set_req(1, 32'd0, 32'd0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, div_busy_o}, 32'd0);
    chk("reset_valid", {31'd0, div_wb_valid_o}, 32'd0);
    chk("reset_data", div_wb_data_o, 32'd0);
    chk("reset_rd", {27'd0, div_wb_rd_o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("div_20_m3", 0, 32'd20, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFFA, 33, 0, 0);
    do_op("rem_20_m3", 2, 32'd20, 32'hFFFF_FFFD, 5'd5, 32'h0000_0002, 33, 0, 0);
    do_op("divu_max_2", 1, 32'hFFFF_FFFF, 32'd2, 5'd9, 32'h7FFF_FFFF, 33, 0, 0);
    do_op("remu_max_2", 3, 32'hFFFF_FFFF, 32'd2, 5'd9, 32'h0000_0001, 33, 0, 0);
    do_op("div_7_0", 0, 32'd7, 32'd0, 5'd1, 32'hFFFF_FFFF, 1, 0, 0);
    do_op("rem_7_0", 2, 32'd7, 32'd0, 5'd2, 32'h0000_0007, 1, 0, 0);
    do_op("remu_min_0", 3, 32'h8000_0000, 32'd0, 5'd3, 32'h8000_0000, 1, 0, 0);
    do_op("div_ovf", 0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h8000_0000, 1, 0, 0);
    do_op("rem_ovf", 2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h0000_0000, 1, 0, 0);
    do_op("divu_ovf", 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h0000_0000, 33, 0, 0);
    do_op("rem_m7_2", 2, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33, 0, 0);
    do_op("noop_divu", 4, 32'd45, 32'd6, 5'd7, 32'd7, 33, 0, 0);
    // Backpressure with a stray request; the next op follows one clock after the ready edge
    do_op("bp_div", 0, 32'hFFFF_FF9C, 32'd7, 5'd17, 32'hFFFF_FFF2, 33, 5, 1);
    do_op("bp_next", 3, 32'd100, 32'd7, 5'd18, 32'd2, 33, 0, 0);

    // Flush at iteration 10: no result ever appears
    set_req(1, 32'hFFFF_1234, 32'd3, 5'd11);
    req_div_i = 1'b1;
    @(posedge clk); #1;
    req_div_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_busy", {31'd0, div_busy_o}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (div_wb_valid_o) seen = 1;
    end
    chk("flush_no_valid", {31'd0, seen}, 32'd0);
    // Flush in IDLE blocks an accompanying request
    @(posedge clk); #1;
    set_req(1, 32'd50, 32'd5, 5'd12);
    req_div_i = 1'b1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    req_div_i = 1'b0;
    flush_i = 1'b0;
    chk("idle_flush_busy", {31'd0, div_busy_o}, 32'd0);
    do_op("divu_100_7", 1, 32'd100, 32'd7, 5'd13, 32'd14, 33, 0, 0);

    // Flush together with ready while holding a result
    set_req(0, 32'd50, 32'd7, 5'd14);
    req_div_i = 1'b1;
    @(posedge clk); #1;
    req_div_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (div_wb_valid_o) seen = 1;
    end
    chk("flush_rdy_seen", {31'd0, seen}, 32'd1);
    flush_i = 1'b1;
    div_wb_ready_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    div_wb_ready_i = 1'b0;
    chk("flush_rdy_busy", {31'd0, div_busy_o}, 32'd0);
    chk("flush_rdy_valid", {31'd0, div_wb_valid_o}, 32'd0);

    // Asynchronous reset mid-calculation
    set_req(1, 32'd1000, 32'd3, 5'd21);
    req_div_i = 1'b1;
    @(posedge clk); #1;
    req_div_i = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, div_busy_o}, 32'd0);
    chk("arst_valid", {31'd0, div_wb_valid_o}, 32'd0);
    chk("arst_data", div_wb_data_o, 32'd0);
    chk("arst_rd", {27'd0, div_wb_rd_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic with random ready and occasional flush
    for (int i = 0; i < 3000; i++) begin
      set_req($urandom_range(0, 4), pick(), pick(), 5'($urandom_range(0, 31)));
      req_div_i      = ($urandom_range(0, 3) == 0);
      div_wb_ready_i = ($urandom_range(0, 2) != 0);
      flush_i        = ($urandom_range(0, 80) == 0);
      @(posedge clk); #1;
    end
    req_div_i = 1'b0;
    flush_i = 1'b0;
    div_wb_ready_i = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("drain_busy", {31'd0, div_busy_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
